regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 16 +
 rtl/regfile_mp_rdport.sv | 56 +++++
 rtl/regfile_mp.sv | 127 ++++++++++++
 tb/tb_regfile_mp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared types and default parameters for regfile_mp
// Contents: state_e (ST_CLEAR, ST_RUN) and DEF_* parameter defaults.
package regfile_mp_pkg;

  // ST_CLEAR: zeroing sweep in progress. ST_RUN: normal operation.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/regfile_mp_rdport.sv
// rtl/regfile_mp_rdport.sv - one combinational read port of regfile_mp
// Ports:
//   i_ready      block is in RUN; when low the port returns zero data and busy
//   i_addr       register address for this port
//   i_mem        flattened register contents, entry k at [k*WIDTH +: WIDTH]
//   i_busy       scoreboard busy bits, one per register
//   i_byp_valid  a write is landing this cycle and may be forwarded
//   i_byp_addr   address of that write
//   i_byp_data   data of that write
//   o_data       read data
//   o_busy       busy bit of the addressed register
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     i_ready,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DEPTH*WIDTH-1:0]   i_mem,
  input  logic [DEPTH-1:0]         i_busy,
  input  logic                     i_byp_valid,
  input  logic [$clog2(DEPTH)-1:0] i_byp_addr,
  input  logic [WIDTH-1:0]         i_byp_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_busy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] w_sel_data;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_addr == AW'(i)) begin
        w_sel_data = i_mem[i*WIDTH +: WIDTH];
      end
    end

    o_data = w_sel_data;
    o_busy = i_busy[i_addr];

    // The hard-wired zero register and the clearing sweep both mask everything,
    // including any forwarded write.
    if (!i_ready || (ZERO_REG != 0 && i_addr == '0)) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (i_byp_valid && i_addr == i_byp_addr) begin
      o_data = i_byp_data;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with busy scoreboard and clearing sweep
// Build option: REGFILE_MP_BYPASS_EN forwards a same-cycle RUN write to matching read ports.
// Ports:
//   clock             rising-edge clock
//   ctrl_reset        synchronous active-high reset, restarts the clearing sweep
//   ctrl_writeEnable  write strobe
//   ctrl_writeReg     write address
//   data_writeReg     write data
//   ctrl_setBusy      mark ctrl_busyReg as pending-write
//   ctrl_busyReg      address to mark busy
//   ctrl_readReg      packed read addresses, port k at [k*AW +: AW]
//   data_readReg      packed read data, port k at [k*WIDTH +: WIDTH]
//   busy_readReg      per-port busy bit of the addressed register
//   ready             high once the sweep is complete
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic                           ctrl_writeEnable,
  input  logic [$clog2(DEPTH)-1:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0]               data_writeReg,
  input  logic                           ctrl_setBusy,
  input  logic [$clog2(DEPTH)-1:0]       ctrl_busyReg,
  input  logic [NREAD*$clog2(DEPTH)-1:0] ctrl_readReg,
  output logic [NREAD*WIDTH-1:0]         data_readReg,
  output logic [NREAD-1:0]               busy_readReg,
  output logic                           ready
);

  localparam int AW = $clog2(DEPTH);

  state_e           r_state;
  logic [AW-1:0]    r_idx;
  logic             r_ready;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic             w_run;
  logic             w_wr_valid;
  logic             w_sb_valid;
  logic             w_sweep_last;
  logic             w_byp_valid;
  logic [DEPTH*WIDTH-1:0] w_mem_flat;

  assign w_run        = (r_state == ST_RUN);
  assign w_wr_valid   = w_run && ctrl_writeEnable && !(ZERO_REG != 0 && ctrl_writeReg == '0);
  assign w_sb_valid   = w_run && ctrl_setBusy && !(ZERO_REG != 0 && ctrl_busyReg == '0);
  assign w_sweep_last = (r_idx == AW'(DEPTH - 1));
  assign ready        = r_ready;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      if (w_sweep_last) begin
        r_state <= ST_RUN;
        r_ready <= 1'b1;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Contents are only ever zeroed one entry per cycle by the sweep, never in bulk.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_idx] <= '0;
      end else if (w_wr_valid) begin
        r_mem[ctrl_writeReg] <= data_writeReg;
      end
    end
  end

  // setBusy is applied after the write clear so that it wins on the same address.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      if (r_state == ST_CLEAR) begin
        r_busy[r_idx] <= 1'b0;
      end else begin
        if (w_wr_valid) begin
          r_busy[ctrl_writeReg] <= 1'b0;
        end
        if (w_sb_valid) begin
          r_busy[ctrl_busyReg] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign w_mem_flat[g*WIDTH +: WIDTH] = r_mem[g];
  end

`ifdef REGFILE_MP_BYPASS_EN
  assign w_byp_valid = w_wr_valid;
`else
  assign w_byp_valid = 1'b0;
`endif

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_mp_rdport #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .i_ready     (r_ready),
      .i_addr      (ctrl_readReg[k*AW +: AW]),
      .i_mem       (w_mem_flat),
      .i_busy      (r_busy),
      .i_byp_valid (w_byp_valid),
      .i_byp_addr  (ctrl_writeReg),
      .i_byp_data  (data_writeReg),
      .o_data      (data_readReg[k*WIDTH +: WIDTH]),
      .o_busy      (busy_readReg[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (default parameters)
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        ctrl_setBusy;
  logic [4:0]  ctrl_busyReg;
  logic [9:0]  ctrl_readReg;
  logic [63:0] data_readReg;
  logic [1:0]  busy_readReg;
  logic        ready;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_mp dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_setBusy     (ctrl_setBusy),
    .ctrl_busyReg     (ctrl_busyReg),
    .ctrl_readReg     (ctrl_readReg),
    .data_readReg     (data_readReg),
    .busy_readReg     (busy_readReg),
    .ready            (ready)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sb;
    logic [4:0]  ba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic        eb0;
    logic [31:0] ed1;
    logic        eb1;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] ed0, input logic eb0,
                        input logic [31:0] ed1, input logic eb1);
    chk($sformatf("%s d0", tag), data_readReg[31:0], ed0);
    chk($sformatf("%s b0", tag), 32'(busy_readReg[0]), 32'(eb0));
    chk($sformatf("%s d1", tag), data_readReg[63:32], ed1);
    chk($sformatf("%s b1", tag), 32'(busy_readReg[1]), 32'(eb1));
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic sb, input logic [4:0] ba,
                        input logic [4:0] ra0, input logic [4:0] ra1);
    ctrl_writeEnable = we;
    ctrl_writeReg    = wa;
    data_writeReg    = wd;
    ctrl_setBusy     = sb;
    ctrl_busyReg     = ba;
    ctrl_readReg     = {ra1, ra0};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic addv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic sb, input logic [4:0] ba,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [31:0] ed0, input logic eb0,
                      input logic [31:0] ed1, input logic eb1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.sb = sb; v.ba = ba;
    v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.eb0 = eb0; v.ed1 = ed1; v.eb1 = eb1;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] byp_exp;

    // Reads in each row see state from earlier rows only; a row never reads the
    // address it writes, so expectations hold with or without forwarding.
    addv(1, 5,  32'hDEADBEEF, 0, 0,  0,  0,  32'h0,        0, 32'h0,        0);
    addv(0, 0,  32'h0,        0, 0,  5,  5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    addv(1, 0,  32'h12345678, 1, 0,  5,  0,  32'hDEADBEEF, 0, 32'h0,        0);
    addv(0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        0, 32'h0,        0);
    addv(0, 0,  32'h0,        1, 7,  7,  5,  32'h0,        0, 32'hDEADBEEF, 0);
    addv(0, 0,  32'h0,        0, 0,  7,  5,  32'h0,        1, 32'hDEADBEEF, 0);
    addv(1, 7,  32'hA5,       0, 0,  5,  9,  32'hDEADBEEF, 0, 32'h0,        0);
    addv(1, 9,  32'h99,       1, 9,  7,  7,  32'hA5,       0, 32'hA5,       0);
    addv(0, 0,  32'h0,        0, 0,  9,  7,  32'h99,       1, 32'hA5,       0);
    addv(1, 31, 32'hFFFFFFFF, 0, 0,  9,  5,  32'h99,       1, 32'hDEADBEEF, 0);
    addv(0, 0,  32'h0,        0, 0,  31, 1,  32'hFFFFFFFF, 0, 32'h0,        0);
    addv(1, 31, 32'h0,        1, 1,  1,  1,  32'h0,        0, 32'h0,        0);
    addv(0, 0,  32'h0,        0, 0,  31, 1,  32'h0,        0, 32'h0,        1);

    // Power-up: hold reset for a few edges.
    set_in(0, 0, 0, 0, 0, 0, 0);
    ctrl_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold_ready", 32'(ready), 32'h0);
    end
    ctrl_reset = 1'b0;

    // Sweep: ready rises exactly on the 32nd edge after release. A write and
    // setBusy to an already-swept register mid-sweep must be ignored.
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("sweep_ready k=%0d", k), 32'(ready), 32'(k == 32));
      if (k == 20) begin
        set_in(1, 4, 32'h77, 1, 4, 4, 4);
        #1;
        chk_rd("clear_reads", 0, 0, 0, 0);
      end else begin
        set_in(0, 0, 0, 0, 0, 0, 0);
      end
    end

    set_in(0, 0, 0, 0, 0, 4, 4);
    #1;
    chk_rd("clear_write_dropped", 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].we, vt[i].wa, vt[i].wd, vt[i].sb, vt[i].ba, vt[i].ra0, vt[i].ra1);
      #1;
      chk_rd($sformatf("vec%0d", i), vt[i].ed0, vt[i].eb0, vt[i].ed1, vt[i].eb1);
      tick();
    end

    // Same-cycle write and read of r3.
`ifdef REGFILE_MP_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'h0;
`endif
    set_in(1, 3, 32'h55, 0, 0, 3, 3);
    #1;
    chk_rd("same_cycle_r3", byp_exp, 0, byp_exp, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 3, 3);
    #1;
    chk_rd("after_write_r3", 32'h55, 0, 32'h55, 0);

    // Dropped write to r0 is never forwarded.
    set_in(1, 0, 32'hABC, 0, 0, 0, 3);
    #1;
    chk_rd("r0_no_forward", 0, 0, 32'h55, 0);
    tick();

    // Reset again, then interrupt the sweep at index 10.
    set_in(0, 0, 0, 0, 0, 0, 0);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    chk("rerun_ready", 32'(ready), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("partial_sweep_ready", 32'(ready), 32'h0);
    end
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    chk("midsweep_reset_ready", 32'(ready), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("restart_ready k=%0d", k), 32'(ready), 32'(k == 32));
      if (k == 5) begin
        set_in(1, 2, 32'h1234, 1, 2, 2, 2);
      end else begin
        set_in(0, 0, 0, 0, 0, 0, 0);
      end
    end

    set_in(0, 0, 0, 0, 0, 2, 9);
    #1;
    chk_rd("after_restart_r2_r9", 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 3, 5);
    #1;
    chk_rd("after_restart_r3_r5", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
